jk_excite_driver: RTL and testbench

Drives a WIDTH-bit bank of JK flip-flops to a requested next state. For each accepted target it derives the per-bit J/K excitation from the present state and applies it for one cycle. It updates an internal JK-modelled state register and pulses `done`. It is the counterpart of the JK next-state logic: that logic maps (J, K, present state) to next state, and this block maps (present state, next state) to (J, K). It sits between sequence/counter controllers and JK register banks in the flip-flop lab designs.

---
 rtl/jk_excite_driver.sv | 79 +++++++
 tb/tb_jk_excite_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: derives per-bit J/K excitation to move a modelled JK bank to a requested state.
// Define JK_EXCITE_CHECK_EN to add a CHECK state that sets a sticky err when the state misses the target.
module jk_excite_driver #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_tgt_valid,
   input  logic [WIDTH-1:0] i_tgt,
   output logic             o_tgt_ready,
   input  logic             i_frz,
   output logic [WIDTH-1:0] o_j,
   output logic [WIDTH-1:0] o_k,
   output logic [WIDTH-1:0] o_q,
   output logic             o_done,
   output logic [7:0]       o_xfer_cnt,
   output logic             o_err
);
`ifdef JK_EXCITE_CHECK_EN
   typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;
`else
   typedef enum logic {IDLE, APPLY} state_t;
`endif
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_j, r_k, r_q;
   logic [7:0]       r_cnt;
   logic             r_done;
   logic             w_acc;
   assign o_tgt_ready = (r_state == IDLE) & ~i_rst;
   assign w_acc       = i_tgt_valid & o_tgt_ready;
   assign o_j         = r_j;
   assign o_k         = r_k;
   assign o_q         = r_q;
   assign o_done      = r_done;
   assign o_xfer_cnt  = r_cnt;
   always_ff @(posedge i_clk) r_state <= i_rst ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
`ifdef JK_EXCITE_CHECK_EN
      w_next = (r_state == IDLE) ? (w_acc ? APPLY : IDLE) : (r_state == APPLY) ? CHECK : IDLE;
`else
      w_next = (r_state == IDLE) ? (w_acc ? APPLY : IDLE) : IDLE;
`endif
   end
   // Excitation is registered at accept so it is stable for the whole APPLY cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q    <= '0;
         r_j    <= '0;
         r_k    <= '0;
         r_done <= 1'b0;
         r_cnt  <= 8'd0;
      end else begin
         r_done <= r_state == APPLY;
         r_j    <= w_acc ? (i_tgt & ~r_q) : '0;
         r_k    <= w_acc ? (~i_tgt & r_q) : '0;
         if (r_state == APPLY) begin
            r_cnt <= r_cnt + 8'd1;
            if (!i_frz) r_q <= (r_j & ~r_q) | (~r_k & r_q);
         end
      end
   end
`ifdef JK_EXCITE_CHECK_EN
   logic [WIDTH-1:0] r_tgt;
   logic             r_err;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tgt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_acc) r_tgt <= i_tgt;
         if (r_state == CHECK && r_q != r_tgt) r_err <= 1'b1;
      end
   end
   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_jk_excite_driver.sv
// tb_jk_excite_driver: directed vector table, streaming and reset corners, then random transfers
// checked against a target-reaching reference model with an excitation lookup table.
module tb_jk_excite_driver;
`ifdef JK_EXCITE_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0, frz = 1'b0;
   logic [3:0] tgt = 4'd0;
   logic       tgt_ready, done, err;
   logic [3:0] j, k, q;
   logic [7:0] xfer_cnt;
   int         n_run = 0, n_fail = 0;
   logic [3:0] mq;
   logic [7:0] mcnt;
   logic       merr;
   logic [1:0] ex [4];
   typedef struct {
      logic [3:0] t;
      logic       f;
      logic [3:0] ej, ek, eq;
   } vec_t;
   vec_t vecs [7];

   jk_excite_driver #(.WIDTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_tgt_valid(tgt_valid), .i_tgt(tgt), .o_tgt_ready(tgt_ready),
      .i_frz(frz), .o_j(j), .o_k(k), .o_q(q), .o_done(done), .o_xfer_cnt(xfer_cnt), .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic xfer(input logic [3:0] t, input logic f, input logic [3:0] ej, input logic [3:0] ek,
                       input logic [3:0] eq, input logic [7:0] ec, input logic ee);
      tgt_valid = 1'b1; tgt = t; frz = f;
      chk("ready_idle", tgt_ready, 1);
      @(negedge clk);
      tgt_valid = 1'b0;
      chk("apply_j", j, ej);
      chk("apply_k", k, ek);
      chk("apply_done", done, 0);
      chk("apply_ready", tgt_ready, 0);
      @(negedge clk);
      frz = 1'b0;
      chk("q", q, eq);
      chk("done", done, 1);
      chk("cnt", xfer_cnt, ec);
      chk("jk_idle", {j, k}, 0);
      chk("ready_after", tgt_ready, !CHK);
`ifdef JK_EXCITE_CHECK_EN
      @(negedge clk);
      chk("done_once", done, 0);
`endif
      chk("err", err, ee);
   endtask

   task automatic model_xfer(input logic [3:0] t, input logic f);
      logic [3:0] ej, ek;
      for (int b = 0; b < 4; b++) {ej[b], ek[b]} = ex[{mq[b], t[b]}];
      mq   = f ? mq : t;
      mcnt = mcnt + 8'd1;
      merr = merr | (CHK & (mq != t));
      xfer(t, f, ej, ek, mq, mcnt, merr);
   endtask

   initial begin
      int acc [3];
      logic rdy [24];
      int idx;
      logic [3:0] s [3];
      ex[0] = 2'b00; ex[1] = 2'b10; ex[2] = 2'b01; ex[3] = 2'b00;
      vecs[0] = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'b1010};
      vecs[1] = '{4'b0110, 1'b0, 4'b0100, 4'b1000, 4'b0110};
      vecs[2] = '{4'b0110, 1'b0, 4'b0000, 4'b0000, 4'b0110};
      vecs[3] = '{4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0000};
      vecs[4] = '{4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b0000};
      vecs[5] = '{4'b1111, 1'b0, 4'b1111, 4'b0000, 4'b1111};
      vecs[6] = '{4'b0101, 1'b0, 4'b0000, 4'b1010, 4'b0101};
      // Reset
      @(negedge clk);
      chk("ready_in_rst", tgt_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_state", {q, j, k, done, xfer_cnt, err}, 0);
      chk("rst_ready", tgt_ready, 1);
      @(negedge clk);
      // Directed table
      for (int i = 0; i < 7; i++)
         xfer(vecs[i].t, vecs[i].f, vecs[i].ej, vecs[i].ek, vecs[i].eq, 8'(i + 1), CHK && i >= 4);
      mq = 4'b0101; mcnt = 8'd7; merr = CHK;
      // Streaming with tgt_valid held high
      s[0] = 4'h1; s[1] = 4'h2; s[2] = 4'h3;
      idx = 0;
      acc = '{-100, -50, 0};
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         rdy[c] = tgt_ready;
         if (idx < 3) begin
            tgt_valid = 1'b1; tgt = s[idx];
            if (tgt_ready) begin acc[idx] = c; idx++; end
         end else tgt_valid = 1'b0;
      end
      chk("stream_accepts", idx, 3);
      chk("stream_gap1", acc[1] - acc[0], CHK ? 3 : 2);
      chk("stream_gap2", acc[2] - acc[1], CHK ? 3 : 2);
      chk("stream_ready_n2", (acc[0] >= 0 && acc[0] + 2 < 24) ? rdy[acc[0] + 2] : 1'bx, !CHK);
      chk("stream_q", q, 4'h3);
      chk("stream_cnt", xfer_cnt, mcnt + 8'd3);
      mq = 4'h3; mcnt = mcnt + 8'd3;
      // Random transfers, some frozen
      for (int i = 0; i < 40; i++) model_xfer(4'($urandom), ($urandom % 5) == 0);
      // Reset during APPLY aborts the transfer
      tgt_valid = 1'b1; tgt = ~mq; frz = 1'b0;
      @(negedge clk);
      tgt_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("abort_state", {q, j, k, done, xfer_cnt, err}, 0);
      chk("abort_ready_rst", tgt_ready, 0);
      rst = 1'b0;
      #1;
      chk("abort_ready", tgt_ready, 1);
      @(negedge clk);
      chk("abort_no_done", done, 0);
      mq = 4'd0; mcnt = 8'd0; merr = 1'b0;
      // 256 transfers wrap the counter
      for (int i = 0; i < 256; i++) model_xfer(4'($urandom), 1'b0);
      chk("cnt_wrap", xfer_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
